// File: rtl/mem_pkg.sv
// Shared types and constants for the data-memory port arbiter.
// Imported by the arbiter top and its priority sub-block.
package mem_pkg;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE,
        DM_ACC,
        IF_B0,
        IF_B1
    } arb_state_t;

    localparam logic LEN1 = 1'b0;
    localparam logic LEN2 = 1'b1;

endpackage

// File: rtl/mem_arb_prio.sv
// Grant decision between data and fetch requestors.
// Data normally wins; a saturating counter forces fetch through.
module mem_arb_prio #(
    parameter int STARVE_MAX = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic in_idle,
    input  logic if_req,
    input  logic dm_req,
    output logic grant_dm,
    output logic grant_if
);

    localparam int CW = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
    localparam logic [CW-1:0] MAX_C = CW'(STARVE_MAX);

    logic [CW-1:0] starve_cnt;
    logic          starved;

    assign starved  = if_req && (starve_cnt == MAX_C);
    assign grant_dm = in_idle && dm_req && !starved;
    assign grant_if = in_idle && if_req && !grant_dm;

    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt <= '0;
        end else if (grant_if) begin
            starve_cnt <= '0;
        end else if (grant_dm && if_req && starve_cnt != MAX_C) begin
            starve_cnt <= starve_cnt + CW'(1);
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Serialises fetch and data requestors onto the single port of
// the unified data memory; memory read data is asynchronous.
module mem_port_arbiter
    import mem_pkg::*;
#(
    parameter int STARVE_MAX = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    input  logic                if_len,
    output logic                if_ready,
    output logic                if_valid,
    output logic [2*DATA_W-1:0] if_data,
    input  logic                dm_req,
    input  logic                dm_we,
    input  logic [ADDR_W-1:0]   dm_addr,
    input  logic [DATA_W-1:0]   dm_wdata,
    output logic                dm_ready,
    output logic                dm_valid,
    output logic [DATA_W-1:0]   dm_rdata,
    output logic                mem_write,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic [DATA_W-1:0]   mem_rdata
);

    arb_state_t        state;
    logic              lat_we;
    logic              lat_len;
    logic [ADDR_W-1:0] lat_addr;
    logic              in_idle;
    logic              grant_dm;
    logic              grant_if;

    // Nothing is accepted while reset is asserted.
    assign in_idle  = (state == IDLE) && !rst;
    assign dm_ready = grant_dm;
    assign if_ready = grant_if;

    mem_arb_prio #(
        .STARVE_MAX(STARVE_MAX)
    ) u_prio (
        .clk     (clk),
        .rst     (rst),
        .in_idle (in_idle),
        .if_req  (if_req),
        .dm_req  (dm_req),
        .grant_dm(grant_dm),
        .grant_if(grant_if)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            lat_we    <= 1'b0;
            lat_len   <= LEN1;
            lat_addr  <= '0;
            if_valid  <= 1'b0;
            if_data   <= '0;
            dm_valid  <= 1'b0;
            dm_rdata  <= '0;
            mem_write <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            if_valid <= 1'b0;
            dm_valid <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (grant_dm) begin
                        state     <= DM_ACC;
                        lat_we    <= dm_we;
                        lat_addr  <= dm_addr;
                        mem_addr  <= dm_addr;
                        mem_write <= dm_we;
                        mem_wdata <= dm_wdata;
                    end else if (grant_if) begin
                        state    <= IF_B0;
                        lat_len  <= if_len;
                        lat_addr <= if_addr;
                        mem_addr <= if_addr;
                    end
                end
                DM_ACC: begin
                    if (!lat_we) begin
                        dm_rdata <= mem_rdata;
                    end
                    dm_valid  <= 1'b1;
                    mem_write <= 1'b0;
                    mem_addr  <= '0;
                    mem_wdata <= '0;
                    state     <= IDLE;
                end
                IF_B0: begin
                    if_data <= {DATA_W'(0), mem_rdata};
                    if (lat_len == LEN2) begin
                        // Second byte wraps at the top of memory.
                        mem_addr <= lat_addr + ADDR_W'(1);
                        state    <= IF_B1;
                    end else begin
                        mem_addr <= '0;
                        if_valid <= 1'b1;
                        state    <= IDLE;
                    end
                end
                IF_B1: begin
                    if_data[2*DATA_W-1:DATA_W] <= mem_rdata;
                    if_valid <= 1'b1;
                    mem_addr <= '0;
                    state    <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed and randomized checks of the memory port arbiter
// against a shadow memory and an abstract grant-order model.
module tb_mem_port_arbiter;
    import mem_pkg::*;

    localparam int SMAX = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [7:0]  if_addr;
    logic        if_len;
    logic        if_ready;
    logic        if_valid;
    logic [15:0] if_data;
    logic        dm_req;
    logic        dm_we;
    logic [7:0]  dm_addr;
    logic [7:0]  dm_wdata;
    logic        dm_ready;
    logic        dm_valid;
    logic [7:0]  dm_rdata;
    logic        mem_write;
    logic [7:0]  mem_addr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;

    logic [7:0]  mem [256];
    logic        bd_we;
    logic [7:0]  bd_addr;
    logic [7:0]  bd_data;

    logic [7:0]  ref_mem [256];
    logic [7:0]  exp_rdata;
    int          total = 0;
    int          passed = 0;
    int          fails = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bd_we) mem[bd_addr] <= bd_data;
        else if (mem_write) mem[mem_addr] <= mem_wdata;
    end
    assign mem_rdata = mem[mem_addr];

    mem_port_arbiter #(.STARVE_MAX(SMAX)) dut (
        .clk      (clk),
        .rst      (rst),
        .if_req   (if_req),
        .if_addr  (if_addr),
        .if_len   (if_len),
        .if_ready (if_ready),
        .if_valid (if_valid),
        .if_data  (if_data),
        .dm_req   (dm_req),
        .dm_we    (dm_we),
        .dm_addr  (dm_addr),
        .dm_wdata (dm_wdata),
        .dm_ready (dm_ready),
        .dm_valid (dm_valid),
        .dm_rdata (dm_rdata),
        .mem_write(mem_write),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    task automatic check(input string tag, input logic [15:0] obs,
                         input logic [15:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Called at posedge+1; returns at posedge+1 of the valid cycle.
    task automatic dm_op(input logic we, input logic [7:0] a,
                         input logic [7:0] wd);
        int n = 0;
        dm_req = 1'b1; dm_we = we; dm_addr = a; dm_wdata = wd;
        #1;
        while (!dm_ready && n < 20) begin
            @(posedge clk); #2; n++;
        end
        check("dm_ready", 16'(dm_ready), 16'd1);
        check("dm_excl", 16'(if_ready), 16'd0);
        @(posedge clk); #1;
        dm_req = 1'b0;
        check("dm_addr", 16'(mem_addr), 16'(a));
        check("dm_wr", 16'(mem_write), 16'(we));
        if (we) check("dm_wdata", 16'(mem_wdata), 16'(wd));
        @(posedge clk); #1;
        if (we) ref_mem[a] = wd;
        else exp_rdata = ref_mem[a];
        check("dm_valid", 16'(dm_valid), 16'd1);
        check("dm_rdata", 16'(dm_rdata), 16'(exp_rdata));
        check("dm_wr_off", 16'(mem_write), 16'd0);
    endtask

    task automatic if_op(input logic [7:0] a, input logic len);
        int n = 0;
        logic [7:0] a1;
        logic [15:0] exp;
        a1 = a + 8'd1;
        exp = (len == LEN2) ? {ref_mem[a1], ref_mem[a]} : {8'h00, ref_mem[a]};
        if_req = 1'b1; if_addr = a; if_len = len;
        #1;
        while (!if_ready && n < 20) begin
            @(posedge clk); #2; n++;
        end
        check("if_ready", 16'(if_ready), 16'd1);
        @(posedge clk); #1;
        if_req = 1'b0;
        check("if_addr0", 16'(mem_addr), 16'(a));
        check("if_nowr", 16'(mem_write), 16'd0);
        @(posedge clk); #1;
        if (len == LEN2) begin
            check("if_early", 16'(if_valid), 16'd0);
            check("if_addr1", 16'(mem_addr), 16'(a1));
            @(posedge clk); #1;
        end
        check("if_valid", 16'(if_valid), 16'd1);
        check("if_data", if_data, exp);
    endtask

    // Both requestors held high; grant order from a streak count.
    task automatic contend(input int ncyc);
        int streak = 0;
        int ngrant = 0;
        logic want_f;
        dm_req = 1'b1; dm_we = 1'b0; dm_addr = 8'h10;
        if_req = 1'b1; if_addr = 8'h05; if_len = LEN1;
        for (int c = 0; c < ncyc; c++) begin
            #1;
            if (dm_ready && if_ready) check("both_ready", 16'd1, 16'd0);
            if (dm_ready || if_ready) begin
                want_f = (streak == SMAX);
                check("grant_order", 16'({dm_ready, if_ready}),
                      want_f ? 16'd1 : 16'd2);
                streak = want_f ? 0 : streak + 1;
                ngrant++;
            end
            @(posedge clk); #1;
        end
        dm_req = 1'b0; if_req = 1'b0;
        check("grant_count", 16'(ngrant), 16'((ncyc + 1) / 2));
        exp_rdata = ref_mem[8'h10];
    endtask

    initial begin
        rst = 1'b1;
        if_req = 1'b0; if_addr = '0; if_len = LEN1;
        dm_req = 1'b0; dm_we = 1'b0; dm_addr = '0; dm_wdata = '0;
        bd_we = 1'b0; bd_addr = '0; bd_data = '0;
        exp_rdata = 8'h00;

        for (int i = 0; i < 256; i++) ref_mem[i] = 8'($urandom);
        ref_mem[8'h10] = 8'hAB;
        ref_mem[8'hFF] = 8'h12;
        ref_mem[8'h00] = 8'h34;
        ref_mem[8'h05] = 8'h7E;
        for (int i = 0; i < 256; i++) begin
            bd_we = 1'b1; bd_addr = 8'(i); bd_data = ref_mem[i];
            @(posedge clk); #1;
        end
        bd_we = 1'b0;

        dm_req = 1'b1; if_req = 1'b1;
        #1;
        check("rst_dm_ready", 16'(dm_ready), 16'd0);
        check("rst_if_ready", 16'(if_ready), 16'd0);
        dm_req = 1'b0; if_req = 1'b0;
        check("rst_outs", 16'({if_valid, dm_valid, mem_write}), 16'd0);
        check("rst_addr", 16'(mem_addr), 16'd0);
        check("rst_dm_rdata", 16'(dm_rdata), 16'd0);
        check("rst_if_data", if_data, 16'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        dm_op(1'b0, 8'h10, 8'h00);
        dm_op(1'b1, 8'h20, 8'h5C);
        dm_op(1'b0, 8'h20, 8'h00);
        if_op(8'hFF, LEN2);
        if_op(8'h05, LEN1);

        contend(20);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_rdata = 8'h00;
        check("rst_cnt_rdata", 16'(dm_rdata), 16'd0);
        contend(20);

        if_req = 1'b1; if_addr = 8'h40; if_len = LEN2;
        #1;
        check("mid_if_ready", 16'(if_ready), 16'd1);
        @(posedge clk); #1;
        if_req = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_rdata = 8'h00;
        check("mid_if_valid", 16'(if_valid), 16'd0);
        check("mid_if_data", if_data, 16'd0);
        check("mid_outs", 16'({dm_valid, mem_write, dm_ready, if_ready}), 16'd0);
        check("mid_addr", 16'(mem_addr), 16'd0);
        check("mid_rdata", 16'(dm_rdata), 16'd0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("mid_no_pulse", 16'(if_valid), 16'd0);
        end
        dm_op(1'b0, 8'h10, 8'h00);

        for (int k = 0; k < 40; k++) begin
            int op;
            op = int'($urandom_range(0, 2));
            if (op == 0) dm_op(1'b0, 8'($urandom), 8'h00);
            else if (op == 1) dm_op(1'b1, 8'($urandom), 8'($urandom));
            else if_op(8'($urandom), 1'($urandom));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Sits directly upstream of the unified 256x8 data memory and is the only block that drives its port (mem_write, addr, write_data), sampling its asynchronous read_data. It serialises two requestors onto that single port. The instruction-fetch side reads 1- or 2-byte instructions. The data side issues byte loads and stores. Data accesses have priority, and a counter guarantees that fetch is never starved.

Parameters:
ADDR_W, 8, address width; memory depth is 2**ADDR_W.
DATA_W, 8, memory word width.
STARVE_MAX, 3, consecutive data grants allowed while fetch is waiting before fetch is forced to win.

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  synchronous reset, active-high.
if_req  in  1  fetch request; held stable with if_addr/if_len until if_ready.
if_addr  in  ADDR_W  fetch start address.
if_len  in  1  0 = 1 byte, 1 = 2 bytes.
if_ready  out  1  fetch request accepted this cycle.
if_valid  out  1  one-cycle pulse; if_data valid.
if_data  out  2*DATA_W  [7:0] = mem[addr], [15:8] = mem[addr+1] (0 if len = 1).
dm_req  in  1  data request; held stable with dm_we/dm_addr/dm_wdata until dm_ready.
dm_we  in  1  1 = store, 0 = load.
dm_addr  in  ADDR_W  data address.
dm_wdata  in  DATA_W  store data.
dm_ready  out  1  data request accepted this cycle.
dm_valid  out  1  one-cycle completion pulse, for loads and stores.
dm_rdata  out  DATA_W  load result.
mem_write  out  1  memory write enable.
mem_addr  out  ADDR_W  memory address.
mem_wdata  out  DATA_W  memory write data.
mem_rdata  in  DATA_W  memory asynchronous read data.

Behaviour:
- The reset values below apply on reset. The same holds when rst rises mid-operation: the in-flight access is dropped, no valid pulse follows, and mem_write is 0 from the next cycle.
  - FSM goes to IDLE.
  - All outputs, latched request registers and starve_cnt are 0.
- FSM states: IDLE, DM_ACC, IF_B0, IF_B1.
- IDLE:
  - mem_write = 0; mem_addr = 0.
  - dm_ready and if_ready are combinational and at most one is high.
  - Data wins if dm_req && !(if_req && starve_cnt == STARVE_MAX).
  - Otherwise fetch wins if if_req.
  - On acceptance, the request fields are latched: data goes to DM_ACC, fetch goes to IF_B0.
- starve_cnt:
  - Increments when data is accepted while if_req = 1.
  - Clears when a fetch is accepted.
  - Holds in all other cycles; it saturates at STARVE_MAX.
- DM_ACC (cycle T+1 after acceptance at T):
  - mem_addr = latched addr; mem_write = latched we; mem_wdata = latched wdata.
  - For a load, mem_rdata is registered into dm_rdata. For a store, dm_rdata holds its previous value.
  - Next state is IDLE. dm_valid = 1 for exactly cycle T+2.
- IF_B0:
  - mem_addr = addr; mem_rdata is captured into if_data[7:0]; if_data[15:8] is cleared.
  - If len = 1, go to IDLE; if_valid pulses at T+2.
  - If len = 2, go to IF_B1.
- IF_B1:
  - mem_addr = (addr + 1) mod 2**ADDR_W, so 0xFF wraps to 0x00.
  - Captured into if_data[15:8]; go to IDLE; if_valid pulses at T+3.
- Latency: load/store 2 cycles accept-to-valid; fetch 2 cycles (len 1) or 3 cycles (len 2).
  - A new request can be accepted in the same cycle a valid pulses, because the FSM is back in IDLE.
- if_data and dm_rdata hold their values between valid pulses.
- mem_write is high only in DM_ACC with we = 1: exactly one cycle per store.
- No request is accepted outside IDLE. Requestors must hold req until ready.

Decomposition:
- Shared package mem_pkg holds:
  - ADDR_W, DATA_W;
  - the state enum {IDLE, DM_ACC, IF_B0, IF_B1};
  - the if_len encoding constants LEN1 = 0, LEN2 = 1.
- One natural sub-module: mem_arb_prio.
  - Purely the grant decision plus starve_cnt register.
  - Inputs: in_idle, if_req, dm_req. Outputs: grant_dm, grant_if.
- The FSM and datapath stay in mem_port_arbiter.

Test Plan:
1. Load: memory preloaded mem[0x10] = 0xAB; dm_req, we = 0, addr 0x10 at T -> dm_ready at T, mem_addr = 0x10 at T+1, dm_valid at T+2 with dm_rdata = 0xAB.
2. Store then load: store 0x5C to 0x20, then load 0x20 -> mem_write high for exactly one cycle with mem_addr = 0x20; load returns 0x5C; the store's dm_valid leaves dm_rdata unchanged.
3. Wrap fetch: mem[0xFF] = 0x12, mem[0x00] = 0x34; if_addr 0xFF, len 2 -> mem_addr sequence FF, 00; if_valid at T+3 with if_data = 0x3412.
4. Contention: dm_req and if_req held high continuously, STARVE_MAX = 3 -> grant order D, D, D, F, D, D, D, F; no cycle has both readies high.
5. Single-byte fetch: if_addr 0x05, len 1, mem[0x05] = 0x7E -> if_valid at T+2, if_data = 0x007E, mem_write stays 0.
6. Reset mid-op: rst for one cycle while in IF_B1 -> next cycle FSM in IDLE, if_valid never pulses, all outputs 0, starve_cnt 0; a subsequent load completes normally.
